// File: rtl/rect_rasterizer.sv
// Rectangle rasterizer: clears the back buffer after every swap, then paints clipped rectangles
// one pixel per cycle. Define RECT_RASTERIZER_OUTLINE_EN to add outline-only rectangles.
module rect_rasterizer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS),
  localparam int unsigned PIXEL_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        swap,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [X_WIDTH-1:0]          cmd_x0,
  input  logic [Y_WIDTH-1:0]          cmd_y0,
  input  logic [X_WIDTH:0]            cmd_w,
  input  logic [Y_WIDTH:0]            cmd_h,
  input  logic                        cmd_color,
`ifdef RECT_RASTERIZER_OUTLINE_EN
  input  logic                        cmd_outline,
`endif
  output logic                        wr_en,
  output logic [PIXEL_ADDR_WIDTH-1:0] wr_addr,
  output logic                        wr_data,
  output logic                        busy,
  output logic                        overrun
);

  typedef logic [X_WIDTH:0]            xw_t;
  typedef logic [Y_WIDTH:0]            yw_t;
  typedef logic [PIXEL_ADDR_WIDTH-1:0] addr_t;

  localparam int unsigned NumPixels = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam xw_t   HMax    = xw_t'(HOR_ACTIVE_PIXELS);
  localparam yw_t   VMax    = yw_t'(VER_ACTIVE_PIXELS);
  localparam addr_t RowStep = addr_t'(HOR_ACTIVE_PIXELS);
  localparam addr_t LastPix = addr_t'(NumPixels - 1);

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StFill  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       swap_q, swap_d;
  addr_t      addr_q, addr_d;
  addr_t      row_q, row_d;
  xw_t        x_q, x_d, x0_q, x0_d, xe_q, xe_d;
  yw_t        y_q, y_d, y0_q, y0_d, ye_q, ye_d;
  logic       color_q, color_d;
  logic       outline_q, outline_d;
  logic       wr_en_q, wr_en_d;
  addr_t      wr_addr_q, wr_addr_d;
  logic       wr_data_q, wr_data_d;
  logic       overrun_q, overrun_d;

  logic       swap_rise, cmd_hs, cmd_ok, outline_in;
  xw_t        cmd_x0_ext, cmd_xe;
  yw_t        cmd_y0_ext, cmd_ye;
  addr_t      cmd_row;

  xw_t        p_x, p_x0, p_xe, x_last, nx_x;
  yw_t        p_y, p_y0, p_ye, nx_y;
  addr_t      p_row, p_addr, nx_row, nx_addr;
  logic       p_color, p_outline;
  logic       col_end, row_end, rect_done, border_row;

`ifdef RECT_RASTERIZER_OUTLINE_EN
  assign outline_in = cmd_outline;
`else
  assign outline_in = 1'b0;
`endif

  assign swap_rise = swap & ~swap_q;
  assign cmd_ready = (state_q == StIdle) & ce & ~swap_rise;
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign busy      = (state_q != StIdle);

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign overrun = overrun_q;

  // Command decode. The end coordinates are clipped by comparing against the remaining room,
  // so x0 + w never has to be formed at a width where it could wrap.
  always_comb begin
    cmd_x0_ext = {1'b0, cmd_x0};
    cmd_y0_ext = {1'b0, cmd_y0};
    cmd_ok     = (cmd_x0_ext < HMax) && (cmd_y0_ext < VMax) &&
                 (cmd_w != '0) && (cmd_h != '0);
    cmd_xe     = (cmd_w >= HMax - cmd_x0_ext) ? HMax : cmd_x0_ext + cmd_w;
    cmd_ye     = (cmd_h >= VMax - cmd_y0_ext) ? VMax : cmd_y0_ext + cmd_h;
    // Product with a constant: only needed once per command to seed the row base.
    cmd_row    = addr_t'(cmd_y0) * RowStep;
  end

  // Current pixel comes from the command itself on the accept cycle, else from the walker.
  always_comb begin
    if (state_q == StFill) begin
      p_x       = x_q;
      p_y       = y_q;
      p_x0      = x0_q;
      p_xe      = xe_q;
      p_y0      = y0_q;
      p_ye      = ye_q;
      p_row     = row_q;
      p_addr    = addr_q;
      p_color   = color_q;
      p_outline = outline_q;
    end else begin
      p_x       = cmd_x0_ext;
      p_y       = cmd_y0_ext;
      p_x0      = cmd_x0_ext;
      p_xe      = cmd_xe;
      p_y0      = cmd_y0_ext;
      p_ye      = cmd_ye;
      p_row     = cmd_row;
      p_addr    = cmd_row + addr_t'(cmd_x0);
      p_color   = cmd_color;
      p_outline = outline_in;
    end

    x_last     = p_xe - xw_t'(1);
    col_end    = (p_x == x_last);
    row_end    = (p_y == p_ye - yw_t'(1));
    rect_done  = col_end & row_end;
    border_row = (p_y == p_y0) | row_end;

    nx_x    = p_x + xw_t'(1);
    nx_y    = p_y;
    nx_row  = p_row;
    nx_addr = p_addr + addr_t'(1);
    if (col_end) begin
      nx_x    = p_x0;
      nx_y    = p_y + yw_t'(1);
      nx_row  = p_row + RowStep;
      nx_addr = p_row + RowStep + addr_t'(p_x0);
    end else if (p_outline && !border_row && (p_x == p_x0)) begin
      // Interior rows of an outline only touch the two side columns.
      nx_x    = x_last;
      nx_addr = p_row + addr_t'(x_last);
    end
  end

  always_comb begin
    state_d   = state_q;
    swap_d    = swap_q;
    addr_d    = addr_q;
    row_d     = row_q;
    x_d       = x_q;
    y_d       = y_q;
    x0_d      = x0_q;
    xe_d      = xe_q;
    y0_d      = y0_q;
    ye_d      = ye_q;
    color_d   = color_q;
    outline_d = outline_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    overrun_d = 1'b0;

    if (ce) begin
      swap_d = swap;
      if (swap_rise) begin
        state_d   = StClear;
        addr_d    = '0;
        overrun_d = (state_q != StIdle);
      end else begin
        case (state_q)
          StClear: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = 1'b0;
            addr_d    = addr_q + addr_t'(1);
            if (addr_q == LastPix) begin
              state_d = StIdle;
            end
          end
          StIdle: begin
            if (cmd_hs && cmd_ok) begin
              wr_en_d   = 1'b1;
              wr_addr_d = p_addr;
              wr_data_d = p_color;
              x0_d      = cmd_x0_ext;
              xe_d      = cmd_xe;
              y0_d      = cmd_y0_ext;
              ye_d      = cmd_ye;
              color_d   = cmd_color;
              outline_d = outline_in;
              x_d       = nx_x;
              y_d       = nx_y;
              row_d     = nx_row;
              addr_d    = nx_addr;
              state_d   = rect_done ? StIdle : StFill;
            end
          end
          StFill: begin
            wr_en_d   = 1'b1;
            wr_addr_d = p_addr;
            wr_data_d = p_color;
            x_d       = nx_x;
            y_d       = nx_y;
            row_d     = nx_row;
            addr_d    = nx_addr;
            state_d   = rect_done ? StIdle : StFill;
          end
          default: begin
            state_d = StClear;
            addr_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      swap_q    <= 1'b0;
      addr_q    <= '0;
      row_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      xe_q      <= '0;
      y0_q      <= '0;
      ye_q      <= '0;
      color_q   <= 1'b0;
      outline_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      swap_q    <= swap_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x0_q      <= x0_d;
      xe_q      <= xe_d;
      y0_q      <= y0_d;
      ye_q      <= ye_d;
      color_q   <= color_d;
      outline_q <= outline_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
